// File: rtl/data_forward_unit.sv
// ID-stage forwarding select producer: shadows EX/MEM destinations, drives select codes and load-use/freeze stall controls.
// Optional FWD_PERF_CNT_EN adds a 32-bit counter of injected load-use bubbles.
module data_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_reg,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  mem_ready,
  output logic [1:0]            forward_data1,
  output logic [1:0]            forward_data2,
  output logic                  stall_id,
  output logic                  bubble_ex
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_load_use_cnt
`endif
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  logic                  ex_v_reg, ex_wr_reg, ex_ld_reg;
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic                  mem_v_reg, mem_wr_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;

  logic [REG_ADDR_W-1:0] rs   [2];
  logic [1:0]            used;
  logic [1:0]            hit_ex;
  logic [1:0]            hit_mem;
  logic [1:0]            fwd  [2];
  logic                  load_use;
  logic                  ex_kill;

  assign rs[0]   = id_rs1;
  assign rs[1]   = id_rs2;
  assign used    = {id_rs2_used, id_rs1_used};

  assign load_use = id_valid & ~flush & (|hit_ex) & ex_ld_reg;
  assign ex_kill  = flush | load_use | ~id_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      assign hit_ex[gi]  = ex_v_reg & ex_wr_reg & (ex_rd_reg == rs[gi]) &
                           (rs[gi] != ZERO) & used[gi];
      assign hit_mem[gi] = mem_v_reg & mem_wr_reg & (mem_rd_reg == rs[gi]) &
                           (rs[gi] != ZERO) & used[gi];
      // Youngest producer wins; an operand waiting on a load reads the regfile
      // until the load reaches MEM on the next advancing cycle.
      always_comb begin
        fwd[gi] = 2'b00;
        if (hit_ex[gi] & ~ex_ld_reg)
          fwd[gi] = 2'b01;
        else if (hit_ex[gi] & load_use)
          fwd[gi] = 2'b00;
        else if (hit_mem[gi])
          fwd[gi] = 2'b10;
      end
    end
  endgenerate

  assign forward_data1 = fwd[0];
  assign forward_data2 = fwd[1];
  assign stall_id      = load_use | ~mem_ready;
  assign bubble_ex     = load_use & mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_reg   <= 1'b0;
      ex_rd_reg  <= '0;
      ex_wr_reg  <= 1'b0;
      ex_ld_reg  <= 1'b0;
      mem_v_reg  <= 1'b0;
      mem_rd_reg <= '0;
      mem_wr_reg <= 1'b0;
    end else if (mem_ready) begin
      mem_v_reg  <= ex_v_reg;
      mem_rd_reg <= ex_rd_reg;
      mem_wr_reg <= ex_wr_reg;
      if (ex_kill) begin
        ex_v_reg  <= 1'b0;
        ex_rd_reg <= '0;
        ex_wr_reg <= 1'b0;
        ex_ld_reg <= 1'b0;
      end else begin
        ex_v_reg  <= 1'b1;
        ex_rd_reg <= id_rd;
        ex_wr_reg <= id_wr_reg;
        ex_ld_reg <= id_is_load;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cnt_reg <= '0;
    else if (bubble_ex)
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
  end

  assign perf_load_use_cnt = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_data_forward_unit.sv
// Directed scoreboard bench for data_forward_unit: expected outputs are queued as each
// cycle's ID inputs are driven and popped/compared at the following falling edge.
module tb_data_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_wr_reg, id_is_load;
  logic       flush, mem_ready;
  logic [1:0] forward_data1, forward_data2;
  logic       stall_id, bubble_ex;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt;
`endif

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic       st;
    logic       bu;
  } exp_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  data_forward_unit #(.REG_ADDR_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .flush(flush), .mem_ready(mem_ready),
    .forward_data1(forward_data1), .forward_data2(forward_data2),
    .stall_id(stall_id), .bubble_ex(bubble_ex)
`ifdef FWD_PERF_CNT_EN
    , .perf_load_use_cnt(perf_load_use_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit fl, input bit mr);
    id_valid    = v;
    id_rs1      = 5'(r1);
    id_rs1_used = u1;
    id_rs2      = 5'(r2);
    id_rs2_used = u2;
    id_rd       = 5'(rd);
    id_wr_reg   = wr;
    id_is_load  = ld;
    flush       = fl;
    mem_ready   = mr;
  endtask

  // One pipeline cycle: drive, queue expectation, compare at negedge, advance past posedge.
  task automatic cyc(input string tag, input bit v, input int r1, input bit u1, input int r2,
                     input bit u2, input int rd, input bit wr, input bit ld, input bit fl,
                     input bit mr, input logic [1:0] e1, input logic [1:0] e2,
                     input logic es, input logic eb);
    exp_t e;
    drive(v, r1, u1, r2, u2, rd, wr, ld, fl, mr);
    sb.push_back({e1, e2, es, eb});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".fwd1"},   32'(forward_data1), 32'(e.f1));
    check({tag, ".fwd2"},   32'(forward_data2), 32'(e.f2));
    check({tag, ".stall"},  32'(stall_id),      32'(e.st));
    check({tag, ".bubble"}, 32'(bubble_ex),     32'(e.bu));
    $display("cycle %-12s fwd1=%b fwd2=%b stall=%b bubble=%b", tag,
             forward_data1, forward_data2, stall_id, bubble_ex);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("rst.fwd1", 32'(forward_data1), 0);
    check("rst.fwd2", 32'(forward_data2), 0);
    check("rst.stall", 32'(stall_id), 0);
    check("rst.bubble", 32'(bubble_ex), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef FWD_PERF_CNT_EN
    check("perf.reset", perf_load_use_cnt, 0);
`endif

    //     tag          v  rs1 u1 rs2 u2 rd wr ld fl mr  e1     e2     st bu
    cyc("idle0",        0, 5,  1, 5,  1, 5, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("idle1",        0, 0,  0, 0,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("addi_x5",      1, 0,  0, 0,  0, 5, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("add_x5x5",     1, 5,  1, 5,  1, 6, 1, 0, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("lw_x7",        1, 1,  1, 0,  0, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("lu_stall",     1, 2,  1, 7,  1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1);
    cyc("lu_resolve",   1, 2,  1, 7,  1, 8, 1, 0, 0, 1, 2'b00, 2'b10, 0, 0);
`ifdef FWD_PERF_CNT_EN
    check("perf.one", perf_load_use_cnt, 1);
`endif
    cyc("wr_x3_a",      1, 0,  0, 0,  0, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("wr_x3_b",      1, 0,  0, 0,  0, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("ex_priority",  1, 3,  1, 3,  0, 0, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0);
    cyc("x0_no_fwd",    1, 0,  1, 3,  1, 9, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    cyc("lw_x7_b",      1, 0,  0, 0,  0, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lu_wait%0d", i),
                        1, 0,  0, 7,  1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    cyc("lu_go",        1, 0,  0, 7,  1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1);
    cyc("lu_fwd_mem",   1, 0,  0, 7,  1, 8, 1, 0, 0, 1, 2'b00, 2'b10, 0, 0);
`ifdef FWD_PERF_CNT_EN
    check("perf.two", perf_load_use_cnt, 2);
`endif
    cyc("freeze_idle",  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    cyc("lw_x7_c",      1, 0,  0, 0,  0, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
    cyc("flush_lu",     1, 0,  0, 7,  1, 8, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    cyc("after_flush",  1, 8,  1, 7,  1, 10, 1, 1, 0, 1, 2'b00, 2'b10, 0, 0);

    // Load x10 now in EX: create a load-use stall, then pulse rst between edges.
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0, 1);
    #1;
    check("pre_rst.stall", 32'(stall_id), 1);
    check("pre_rst.bubble", 32'(bubble_ex), 1);
    rst = 1'b1;
    #1;
    check("mid_rst.stall", 32'(stall_id), 0);
    check("mid_rst.bubble", 32'(bubble_ex), 0);
    check("mid_rst.fwd1", 32'(forward_data1), 0);
    $display("cycle %-12s stall=%b bubble=%b", "mid_rst", stall_id, bubble_ex);
`ifdef FWD_PERF_CNT_EN
    check("perf.rst", perf_load_use_cnt, 0);
`endif
    id_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc("post_rst",     1, 10, 1, 10, 1, 12, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);

    check("sb.empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
